instruction_sequencer: RTL
==========================

# instruction_sequencer

Issuing end of the control-unit handshake: holds a small loadable program of 7-bit function words plus immediates, and presents them one at a time on the `function`/`w` pair. After each issue it waits for the control unit's `done` before advancing. Sits between a host/testbench loader and the control unit; its `ext_data` drives the processor's external data bus for load-external instructions.

## Interface
- `DEPTH`, 16, program words; power of two.
- `AW`, $clog2(DEPTH), program address width.
- `DW`, 8, immediate/data-bus width.
- `TIMEOUT`, 15, max WAIT cycles without `done`; used only with `SEQ_TIMEOUT_EN`.
- `clk`  in  1  rising-edge clock; the only clock.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `prog_we`  in  1  program write strobe, honoured only in IDLE.
- `prog_addr`  in  AW  write address.
- `prog_func`  in  7  function word to store: [6] store, [5:4] opcode, [3:2] X, [1:0] Y.
- `prog_imm`  in  DW  immediate to store with it.
- `prog_len`  in  AW+1  number of words to run from address 0, sampled on `start`.
- `start`  in  1  begin execution, sampled in IDLE or ERROR.
- `abort`  in  1  synchronous return to IDLE from any state.
- `done`  in  1  control-unit completion.
- `function`  out  7  current function word, registered.
- `w`  out  1  issue strobe, one cycle per instruction.
- `ext_data`  out  DW  immediate of current instruction.
- `busy`  out  1  high in ISSUE and WAIT.
- `pc`  out  AW  index of current instruction.
- `finished`  out  1  one-cycle pulse after last `done`.
- `err`  out  1  timeout flag, sticky.

## Operation
- States: IDLE, ISSUE, WAIT, ERROR.
- IDLE: `prog_we` writes {func, imm} at `prog_addr`. `start` with `prog_len`≠0 latches length, pc←0, goes to ISSUE. `start` with `prog_len`=0 pulses `finished`, stays IDLE.
- ISSUE, exactly one cycle: `w`=1, `function`/`ext_data` = mem[pc], then WAIT.
- WAIT: `w`=0, `function`/`ext_data` held stable.
  - On `done`, if pc = len−1: `finished` pulse, go to IDLE.
  - On `done` otherwise: pc←pc+1, go to ISSUE.
- `done` outside WAIT is ignored. `start` while busy is ignored. `prog_we` outside IDLE is ignored; memory is unchanged.
- `abort` has priority over every transition. It goes to IDLE with `w`=0, pc←0, and `finished` not pulsed. `err` is unaffected.
- pc never wraps: at most `DEPTH` words are run, and `prog_len` > DEPTH is saturated to DEPTH.
- Reset mid-operation: all outputs go to 0 immediately and the state goes to IDLE. Program memory is not reset; its contents are undefined until written.

## Timing
- Reset values: `function`=0, `w`=0, `ext_data`=0, `busy`=0, `pc`=0, `finished`=0, `err`=0.
- `start` sampled at edge k → `w`=1 during cycle k+1.
- `done` sampled at edge m → next `w`=1 during cycle m+1. This gives one idle cycle between instructions, so the control-unit step counter has returned to T0 when `w` rises.
- `finished` is high in the cycle after the final `done` edge.
- A program write at edge k is readable by a `start` at edge k+1.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A WAIT cycle counter clears on each entry to WAIT.
  - If `TIMEOUT` cycles elapse in WAIT without `done`, the block goes to ERROR with `err`=1, `w`=0 and `busy`=0.
  - ERROR exits only via `start`, which clears `err`, or via `abort`/reset. `abort` returns to IDLE with `err` still set.
- `SEQ_TIMEOUT_EN` undefined: no counter, `err` tied 0, ERROR unreachable, and WAIT waits indefinitely.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum;
  - `FUNC_W`=7;
  - field constants `STORE_BIT`=6, `OP_HI`=5, `OP_LO`=4, `X_HI`=3, `Y_HI`=1;
  - opcode constants: load-external 00, move 01, add 10, sub 11.
- Sub-module `seq_prog_mem`: DEPTH × (7+DW) register array, synchronous write, asynchronous read. The FSM registers the read data onto `function`/`ext_data` in ISSUE.

## Test plan
- Write 3 words ({0,00,01,00}/imm 0x5A, {0,10,01,10}/0, {1,00,11,00}/0), `prog_len`=3, `start`, model `done` 2/4/2 cycles after each `w` → exactly 3 `w` pulses with the correct words, `ext_data`=0x5A during the first, then a `finished` pulse and `busy`=0.
- Back-to-back timing: `done` asserted the cycle after each `w` → `w` period is exactly 3 cycles and pc runs 0,1,2.
- `start` with `prog_len`=0 → `finished` the next cycle and no `w`. `start` while busy → no restart, pc unchanged.
- `abort` in WAIT at pc=1 → IDLE the next cycle, pc=0, no `finished`. `prog_we` during WAIT → memory unchanged (verify by rerunning).
- `clr_n` low mid-WAIT → all outputs 0 asynchronously. After release, a rerun with the same program behaves as in the first scenario.
- With `SEQ_TIMEOUT_EN`: withhold `done` → `err`=1 exactly `TIMEOUT` cycles after WAIT entry, `busy`=0; a later `start` clears `err` and reissues pc 0. Without the macro: `err` stays 0 and the block stays in WAIT for 100 cycles.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and field layout for the instruction sequencer and its program store.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } seq_state_e;

    // Function word layout: [6] store, [5:4] opcode, [3:2] X, [1:0] Y
    localparam int FUNC_W    = 7;
    localparam int STORE_BIT = 6;
    localparam int OP_HI     = 5;
    localparam int OP_LO     = 4;
    localparam int X_HI      = 3;
    localparam int Y_HI      = 1;

    // Control-unit opcodes
    typedef enum logic [1:0] {
        OP_LOAD_EXT = 2'b00,
        OP_MOVE     = 2'b01,
        OP_ADD      = 2'b10,
        OP_SUB      = 2'b11
    } opcode_e;

    // Pack the individual fields into one function word
    function automatic logic [FUNC_W-1:0] make_func(input logic store, input opcode_e op,
                                                    input logic [1:0] x, input logic [1:0] y);
        logic [FUNC_W-1:0] f;
        f              = '0;
        f[STORE_BIT]   = store;
        f[OP_HI:OP_LO] = op;
        f[X_HI -: 2]   = x;
        f[Y_HI -: 2]   = y;
        return f;
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x {function word, immediate}, synchronous write, asynchronous read.
// Latency: a write at edge k is visible on the read port right after edge k.
// Backpressure: none; the caller gates the write strobe.
module seq_prog_mem
    import seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [FUNC_W-1:0] wfunc,
    input  logic [DW-1:0]     wimm,
    input  logic [AW-1:0]     raddr,
    output logic [FUNC_W-1:0] rfunc,
    output logic [DW-1:0]     rimm
);

    logic [FUNC_W+DW-1:0] mem [DEPTH];

    // Contents are deliberately not reset; a word is undefined until written
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= {wfunc, wimm};
        end
    end

    assign {rfunc, rimm} = mem[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Issues a loaded program one function word at a time to the control unit; optional WAIT watchdog under SEQ_TIMEOUT_EN.
// Latency: start at edge k -> w high after edge k+1; done at edge m -> next w after edge m+1; finished right after the last done edge.
// Backpressure: each issue stalls in WAIT until done (or, with SEQ_TIMEOUT_EN, until the watchdog trips into ERROR).
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [FUNC_W-1:0] prog_func,
    input  logic [DW-1:0]     prog_imm,
    input  logic [AW:0]       prog_len,
    input  logic              start,
    input  logic              abort,
    input  logic              done,
    // current function word (named func since "function" is a reserved word)
    output logic [FUNC_W-1:0] func,
    output logic              w,
    output logic [DW-1:0]     ext_data,
    output logic              busy,
    output logic [AW-1:0]     pc,
    output logic              finished,
    output logic              err
);

    seq_state_e        state;
    logic [AW:0]       len;
    logic [AW:0]       len_sat;
    logic              last;
    logic              mem_we;
    logic [FUNC_W-1:0] rd_func;
    logic [DW-1:0]     rd_imm;

    // Lengths beyond the store are clamped so pc can never wrap
    assign len_sat = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    assign last    = ({1'b0, pc} == (len - (AW+1)'(1)));
    assign mem_we  = prog_we && (state == ST_IDLE);
    assign busy    = (state == ST_ISSUE) || (state == ST_WAIT);

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wfunc (prog_func),
        .wimm  (prog_imm),
        .raddr (pc),
        .rfunc (rd_func),
        .rimm  (rd_imm)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    assign err = err_q;
`else
    // TIMEOUT only matters when the watchdog is built in
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;

    assign err = 1'b0;
`endif

    // Control FSM: abort wins over everything, outputs are registered
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            len      <= '0;
            func     <= '0;
            ext_data <= '0;
            w        <= 1'b0;
            finished <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            w        <= 1'b0;
            finished <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                pc    <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_ERROR: begin
                        if (start) begin
`ifdef SEQ_TIMEOUT_EN
                            err_q <= 1'b0;
`endif
                            pc <= '0;
                            if (len_sat == '0) begin
                                // empty program completes immediately
                                finished <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                len   <= len_sat;
                                state <= ST_ISSUE;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        w        <= 1'b1;
                        func     <= rd_func;
                        ext_data <= rd_imm;
                        state    <= ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                    ST_WAIT: begin
                        if (done) begin
                            if (last) begin
                                finished <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                pc    <= pc + AW'(1);
                                state <= ST_ISSUE;
                            end
                        end
`ifdef SEQ_TIMEOUT_EN
                        else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                            err_q <= 1'b1;
                            state <= ST_ERROR;
                        end else begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
